conv_sched_ctrl: RTL and testbench
==================================

Name: conv_sched_ctrl

Overview:
- Top-level sequencer for one convolution layer in the IMG2COL/GEMM datapath.
- On a start request it latches the layer configuration and drives it to the weight address generator and the img2col address generator.
- It runs the weight generator once, then runs the img2col generator and a GEMM drain once per output tile, and signals completion.
- A watchdog and an abort input give it a defined recovery path when a sub-block hangs.

Parameters:
- KS_W, 4, width of kernel_size
- CH_W, 8, width of channels
- KN_W, 8, width of kernel_nums
- TILE_W, 16, width of the tile count and tile index
- TIMEOUT, 4096, maximum cycles allowed in any wait state (must be ≥2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  level; forces return to IDLE
- kernel_size  in  KS_W  layer kernel size
- channels  in  CH_W  input channels
- kernel_nums  in  KN_W  output kernels
- num_tiles  in  TILE_W  output tiles in the layer
- cfg_kernel_size  out  KS_W  latched kernel_size, to both generators
- cfg_channels  out  CH_W  latched channels
- cfg_kernel_nums  out  KN_W  latched kernel_nums
- w_enable  out  1  level enable to the weight address generator
- w_done  in  1  weight generator finished
- i_enable  out  1  level enable to the img2col generator
- i_done  in  1  img2col generator finished the current tile
- gemm_flush  out  1  level request to drain the GEMM array
- gemm_ack  in  1  drain complete
- tile_idx  out  TILE_W  index of the current tile
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; 1 = bad config or timeout

Behaviour:
- Reset: state=IDLE; every output 0, including cfg_* and tile_idx; watchdog=0.
- Registered outputs: every output is a decode of the registered state plus registers. No combinational path from inputs to outputs.
- IDLE:
  - start=1 with kernel_size, channels, kernel_nums and num_tiles all nonzero: latch all four on that edge, tile_idx←0, next state W_LOAD. w_enable is therefore high on the cycle after start.
  - start=1 with any field zero: next state ERR. Nothing is latched.
- W_LOAD: w_enable=1. When w_done=1 is sampled, next state I_LOAD. w_enable drops on the same edge that i_enable rises.
- I_LOAD: i_enable=1. When i_done=1 is sampled, next state DRAIN.
- DRAIN: gemm_flush=1. When gemm_ack=1 is sampled:
  - if tile_idx == num_tiles−1 (latched value), next state FIN;
  - otherwise tile_idx++ and next state I_LOAD.
  - Weights are not reloaded between tiles.
- FIN: done=1, err=0 for exactly one cycle, then IDLE.
- ERR: done=1, err=1 for exactly one cycle, then IDLE.
- Watchdog:
  - Clears on every state change.
  - Increments each cycle spent in W_LOAD, I_LOAD or DRAIN.
  - If the state's exit condition is still false when the count reaches TIMEOUT−1, next state ERR.
- Priority, highest first: rstn, abort, normal exit condition, timeout.
  - A done/ack arriving on the timeout cycle wins over the timeout.
- abort=1 in any non-IDLE state: next state IDLE.
  - w_enable, i_enable and gemm_flush go low on that edge.
  - No done pulse is produced.
  - cfg_* and tile_idx keep their values.
  - abort in IDLE blocks start.
- Sub-block handshake signals are ignored outside their own state: w_done outside W_LOAD, i_done outside I_LOAD, gemm_ack outside DRAIN.
- start while busy is ignored.
- At most one of w_enable, i_enable, gemm_flush is high in any cycle.
- Asynchronous reset asserted mid-operation: all outputs return to 0 immediately. No done pulse.
- cfg_* stay stable from the cycle after start until the next accepted start.

Test Plan:
- Normal run: start with kernel_size=2, channels=3, kernel_nums=10, num_tiles=4; w_done after 5 cycles, each i_done after 8, each gemm_ack after 3.
  -> exactly 1 w_enable window and 4 i_enable/gemm_flush windows; tile_idx steps 0,1,2,3; one done with err=0; busy low the cycle after done.
- Zero config: start with channels=0.
  -> done=1, err=1 on the cycle after start; w_enable never asserted; cfg_* remain 0.
- Timeout: TIMEOUT=16, i_done held low in I_LOAD.
  -> ERR is entered on the edge ending the 16th I_LOAD cycle; one done with err=1; i_enable low that same cycle.
- Timeout tie: i_done=1 on the cycle the watchdog hits 15.
  -> transition to DRAIN, no err.
- Abort: assert abort during the tile-2 DRAIN.
  -> IDLE next cycle, gemm_flush low, no done, tile_idx stays 2; a new start is accepted afterwards and tile_idx resets to 0.
- Spurious and reset cases:
  - gemm_ack pulsed during W_LOAD and start pulsed mid-run -> both ignored.
  - rstn dropped mid-I_LOAD -> all outputs 0 immediately.

Source files
------------

// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: sequencer for one convolution layer of the IMG2COL/GEMM datapath.
// Latches the layer configuration on an accepted start, runs the weight address
// generator once, then for each output tile runs the img2col generator followed
// by a GEMM drain, and finally pulses done (err qualifies bad config / timeout).
// A watchdog bounds every wait state; abort returns to IDLE without a done pulse.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   start, abort                    layer request (IDLE only), level abort
//   kernel_size/channels/
//   kernel_nums/num_tiles           layer configuration inputs
//   cfg_kernel_size/channels/nums   latched configuration to the generators
//   w_enable / w_done               weight generator enable / finished
//   i_enable / i_done               img2col generator enable / tile finished
//   gemm_flush / gemm_ack           GEMM drain request / drain complete
//   tile_idx                        index of the tile being processed
//   busy, done, err                 status; done is a one-cycle pulse
module conv_sched_ctrl #(
  parameter int KS_W    = 4,
  parameter int CH_W    = 8,
  parameter int KN_W    = 8,
  parameter int TILE_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [KS_W-1:0]   kernel_size,
  input  logic [CH_W-1:0]   channels,
  input  logic [KN_W-1:0]   kernel_nums,
  input  logic [TILE_W-1:0] num_tiles,
  output logic [KS_W-1:0]   cfg_kernel_size,
  output logic [CH_W-1:0]   cfg_channels,
  output logic [KN_W-1:0]   cfg_kernel_nums,
  output logic              w_enable,
  input  logic              w_done,
  output logic              i_enable,
  input  logic              i_done,
  output logic              gemm_flush,
  input  logic              gemm_ack,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    W_LOAD,
    I_LOAD,
    DRAIN,
    FIN,
    ERR
  } state_t;

  state_t            state, state_nxt;
  logic [TILE_W-1:0] ntiles_q;
  logic [WD_W-1:0]   wdog;
  logic              accept;
  logic              tile_adv;
  logic              wd_hit;
  logic              cfg_ok;
  logic              last_tile;

  assign wd_hit    = (wdog == WD_W'(TIMEOUT - 1));
  assign cfg_ok    = (kernel_size != '0) && (channels != '0) &&
                     (kernel_nums != '0) && (num_tiles != '0);
  assign last_tile = (tile_idx == ntiles_q - TILE_W'(1));

  // Priority inside each wait state: abort, then the normal exit, then timeout,
  // so a handshake arriving on the timeout cycle still advances normally.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tile_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            state_nxt = W_LOAD;
            accept    = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      W_LOAD: begin
        if (abort)       state_nxt = IDLE;
        else if (w_done) state_nxt = I_LOAD;
        else if (wd_hit) state_nxt = ERR;
      end
      I_LOAD: begin
        if (abort)       state_nxt = IDLE;
        else if (i_done) state_nxt = DRAIN;
        else if (wd_hit) state_nxt = ERR;
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gemm_ack) begin
          if (last_tile) begin
            state_nxt = FIN;
          end else begin
            state_nxt = I_LOAD;
            tile_adv  = 1'b1;
          end
        end else if (wd_hit) begin
          state_nxt = ERR;
        end
      end
      FIN:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cfg_kernel_size <= '0;
      cfg_channels    <= '0;
      cfg_kernel_nums <= '0;
      ntiles_q        <= '0;
      tile_idx        <= '0;
      wdog            <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cfg_kernel_size <= kernel_size;
        cfg_channels    <= channels;
        cfg_kernel_nums <= kernel_nums;
        ntiles_q        <= num_tiles;
        tile_idx        <= '0;
      end else if (tile_adv) begin
        tile_idx <= tile_idx + TILE_W'(1);
      end
      if (state_nxt != state)
        wdog <= '0;
      else if (state == W_LOAD || state == I_LOAD || state == DRAIN)
        wdog <= wdog + WD_W'(1);
      else
        wdog <= '0;
    end
  end

  assign w_enable   = (state == W_LOAD);
  assign i_enable   = (state == I_LOAD);
  assign gemm_flush = (state == DRAIN);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN) || (state == ERR);
  assign err        = (state == ERR);

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Directed bench for conv_sched_ctrl: normal multi-tile run, zero config,
// watchdog timeout and tie, abort, spurious handshakes and mid-run reset.
module tb_conv_sched_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort;
  logic [3:0]  kernel_size;
  logic [7:0]  channels;
  logic [7:0]  kernel_nums;
  logic [15:0] num_tiles;
  logic [3:0]  cfg_kernel_size;
  logic [7:0]  cfg_channels;
  logic [7:0]  cfg_kernel_nums;
  logic        w_enable, w_done, i_enable, i_done, gemm_flush, gemm_ack;
  logic [15:0] tile_idx;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;
  int w_rise = 0, i_rise = 0, g_rise = 0, done_cnt = 0, multi = 0;
  logic w_q = 1'b0, i_q = 1'b0, g_q = 1'b0;
  int d0;

  conv_sched_ctrl #(
    .KS_W(4), .CH_W(8), .KN_W(8), .TILE_W(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .kernel_size(kernel_size), .channels(channels),
    .kernel_nums(kernel_nums), .num_tiles(num_tiles),
    .cfg_kernel_size(cfg_kernel_size), .cfg_channels(cfg_channels),
    .cfg_kernel_nums(cfg_kernel_nums),
    .w_enable(w_enable), .w_done(w_done),
    .i_enable(i_enable), .i_done(i_done),
    .gemm_flush(gemm_flush), .gemm_ack(gemm_ack),
    .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Window / pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (w_enable && !w_q) w_rise++;
    if (i_enable && !i_q) i_rise++;
    if (gemm_flush && !g_q) g_rise++;
    if (done) done_cnt++;
    if ((32'(w_enable) + 32'(i_enable) + 32'(gemm_flush)) > 1) multi++;
    w_q = w_enable;
    i_q = i_enable;
    g_q = gemm_flush;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge samples the start request.
  task automatic start_cfg(input int ks, input int ch, input int kn, input int nt);
    kernel_size = 4'(ks);
    channels    = 8'(ch);
    kernel_nums = 8'(kn);
    num_tiles   = 16'(nt);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Called at the falling edge of the first cycle in a wait state; raises the
  // handshake during the n-th cycle and returns at the first cycle of the next state.
  task automatic pulse_after(input int sel, input int n);
    repeat (n - 1) @(negedge clk);
    case (sel)
      0:       w_done   = 1'b1;
      1:       i_done   = 1'b1;
      default: gemm_ack = 1'b1;
    endcase
    @(negedge clk);
    w_done   = 1'b0;
    i_done   = 1'b0;
    gemm_ack = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    kernel_size = '0; channels = '0; kernel_nums = '0; num_tiles = '0;
    w_done = 1'b0; i_done = 1'b0; gemm_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ks", cfg_kernel_size, 0);
    chk("rst_tile", tile_idx, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Normal run: 4 tiles, w_done after 5, i_done after 8, gemm_ack after 3.
    start_cfg(2, 3, 10, 4);
    chk("n_wen", w_enable, 1);
    chk("n_cfg_ks", cfg_kernel_size, 2);
    chk("n_cfg_ch", cfg_channels, 3);
    chk("n_cfg_kn", cfg_kernel_nums, 10);
    chk("n_tile0", tile_idx, 0);
    pulse_after(0, 5);
    for (int t = 0; t < 4; t++) begin
      chk("n_ien", i_enable, 1);
      chk("n_wen_off", w_enable, 0);
      chk("n_tile", tile_idx, 32'(t));
      pulse_after(1, 8);
      chk("n_flush", gemm_flush, 1);
      pulse_after(2, 3);
    end
    chk("n_done", done, 1);
    chk("n_err", err, 0);
    @(negedge clk);
    chk("n_busy_after", busy, 0);
    #1;
    chk("n_w_windows", w_rise, 1);
    chk("n_i_windows", i_rise, 4);
    chk("n_g_windows", g_rise, 4);
    chk("n_done_cnt", done_cnt, 1);
    @(negedge clk);

    // Zero config after a reset: err pulse, nothing latched.
    rstn = 1'b0;
    #1;
    chk("z_rst_cfg", cfg_kernel_size, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_cfg(2, 0, 10, 4);
    chk("z_done", done, 1);
    chk("z_err", err, 1);
    chk("z_wen", w_enable, 0);
    chk("z_cfg_ch", cfg_channels, 0);
    chk("z_cfg_kn", cfg_kernel_nums, 0);
    @(negedge clk);
    chk("z_busy", busy, 0);

    // Timeout: i_done held low for the full watchdog window.
    start_cfg(1, 1, 1, 2);
    pulse_after(0, 2);
    chk("t_ien1", i_enable, 1);
    repeat (15) @(negedge clk);
    chk("t_ien16", i_enable, 1);
    @(negedge clk);
    chk("t_done", done, 1);
    chk("t_err", err, 1);
    chk("t_ien_off", i_enable, 0);
    @(negedge clk);
    chk("t_busy", busy, 0);

    // Timeout tie: i_done on the watchdog's last cycle wins.
    start_cfg(1, 1, 1, 1);
    pulse_after(0, 2);
    pulse_after(1, 16);
    chk("tie_flush", gemm_flush, 1);
    chk("tie_err", err, 0);
    pulse_after(2, 1);
    chk("tie_done", done, 1);
    chk("tie_err_fin", err, 0);
    @(negedge clk);

    // Abort during the tile-2 drain.
    start_cfg(3, 4, 5, 4);
    pulse_after(0, 1);
    for (int t = 0; t < 2; t++) begin
      pulse_after(1, 1);
      pulse_after(2, 1);
    end
    pulse_after(1, 1);
    chk("a_flush", gemm_flush, 1);
    chk("a_tile2", tile_idx, 2);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    chk("a_busy", busy, 0);
    chk("a_flush_off", gemm_flush, 0);
    chk("a_tile_kept", tile_idx, 2);
    chk("a_cfg_kept", cfg_kernel_size, 3);
    start = 1'b1;                          // abort held: start must be blocked
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("a_blocked", busy, 0);
    chk("a_no_done", done_cnt, d0);

    // Restart, then spurious handshakes / start while busy, then reset mid I_LOAD.
    start_cfg(3, 4, 5, 4);
    chk("r_wen", w_enable, 1);
    chk("r_tile0", tile_idx, 0);
    gemm_ack = 1'b1; i_done = 1'b1; start = 1'b1; kernel_size = 4'd7;
    @(negedge clk);
    gemm_ack = 1'b0; i_done = 1'b0; start = 1'b0;
    chk("s_wen", w_enable, 1);
    chk("s_cfg_ks", cfg_kernel_size, 3);
    pulse_after(0, 1);
    chk("s_ien", i_enable, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("x_ien", i_enable, 0);
    chk("x_busy", busy, 0);
    chk("x_cfg_ks", cfg_kernel_size, 0);
    chk("x_cfg_ch", cfg_channels, 0);
    chk("x_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("x_no_done", done_cnt, d0);
    chk("onehot", multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
